// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI address-channel arbiter.
// Optional feature macro: AXI_ARB_PERF_EN.
package axi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } arb_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic       TYPE_WR     = 1'b1;
  localparam logic       TYPE_RD     = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        typ;
  } arb_cmd_t;

endpackage

// File: rtl/axi_outstanding_ctr.sv
// Saturating in-flight burst counter with limit flag and sticky underflow.
// Optional feature macro: none.
module axi_outstanding_ctr
  import axi_arb_pkg::*;
(
  input  logic       axi_clk,
  input  logic       rstn,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] limit,
  output logic [3:0] count,
  output logic       at_limit,
  output logic       err
);

  assign at_limit = (count >= limit);

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      count <= 4'd0;
      err   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: count <= count + 4'd1;
        2'b01: begin
          // a response with nothing in flight is a slave/protocol error
          if (count == 4'd0) err <= 1'b1;
          else count <= count - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Round-robin write/read arbiter for a shared AXI address channel.
// Optional feature macro: AXI_ARB_PERF_EN (grant and RAW-stall counters).
module axi_cmd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int         ASIZE     = 5,
  parameter int         MAX_OUT   = 4,
  parameter int         RAW_BLOCK = 1,
  parameter logic [7:0] AXI_ID    = 8'h00
) (
  input  logic        axi_clk,
  input  logic        rstn,
  input  logic        wr_req_valid,
  input  logic [31:0] wr_req_addr,
  input  logic [7:0]  wr_req_len,
  output logic        wr_req_ready,
  input  logic        rd_req_valid,
  input  logic [31:0] rd_req_addr,
  input  logic [7:0]  rd_req_len,
  output logic        rd_req_ready,
  output logic [7:0]  aid,
  output logic [31:0] aaddr,
  output logic [7:0]  alen,
  output logic [2:0]  asize,
  output logic [1:0]  aburst,
  output logic [1:0]  alock,
  output logic        avalid,
  output logic        atype,
  input  logic        aready,
  input  logic        bvalid,
  input  logic        bready,
  input  logic        rvalid,
  input  logic        rready,
  input  logic        rlast,
  output logic [3:0]  wr_outstanding,
  output logic [3:0]  rd_outstanding,
  output logic        busy,
  output logic        err
`ifdef AXI_ARB_PERF_EN
  ,
  output logic [31:0] perf_wr_grants,
  output logic [31:0] perf_rd_grants,
  output logic [31:0] perf_raw_stall
`endif
);

  localparam logic [3:0] LIMIT = 4'(MAX_OUT);

  arb_state_e state;
  logic       last_grant;
  logic       hs, wr_hs, rd_hs;
  logic       wr_done, rd_done;
  logic       wr_full, rd_full;
  logic       wr_err, rd_err;
  logic       raw_ok, wr_elig, rd_elig, pick_wr;
  arb_cmd_t   win;

  assign aid    = AXI_ID;
  assign asize  = 3'(ASIZE);
  assign aburst = BURST_INCR;
  assign alock  = LOCK_NORMAL;

  assign hs      = avalid & aready;
  assign wr_hs   = hs & (atype == TYPE_WR);
  assign rd_hs   = hs & (atype == TYPE_RD);
  assign wr_done = bvalid & bready;
  assign rd_done = rvalid & rready & rlast;

  assign wr_req_ready = wr_hs;
  assign rd_req_ready = rd_hs;

  assign raw_ok  = (RAW_BLOCK == 0) || (wr_outstanding == 4'd0);
  assign wr_elig = wr_req_valid & ~wr_full;
  assign rd_elig = rd_req_valid & ~rd_full & raw_ok;
  // on contention the direction not served last time wins
  assign pick_wr = wr_elig & (~rd_elig | (last_grant == TYPE_RD));

  always_comb begin
    win = '{addr: rd_req_addr, len: rd_req_len, typ: TYPE_RD};
    if (pick_wr)
      win = '{addr: wr_req_addr, len: wr_req_len, typ: TYPE_WR};
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      avalid     <= 1'b0;
      aaddr      <= 32'd0;
      alen       <= 8'd0;
      atype      <= TYPE_RD;
      last_grant <= TYPE_RD;
    end else begin
      case (state)
        IDLE: begin
          if (wr_elig | rd_elig) begin
            aaddr  <= win.addr;
            alen   <= win.len;
            atype  <= win.typ;
            avalid <= 1'b1;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (aready) begin
            avalid     <= 1'b0;
            last_grant <= atype;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axi_outstanding_ctr u_wr_ctr (
    .axi_clk  (axi_clk),
    .rstn     (rstn),
    .inc      (wr_hs),
    .dec      (wr_done),
    .limit    (LIMIT),
    .count    (wr_outstanding),
    .at_limit (wr_full),
    .err      (wr_err)
  );

  axi_outstanding_ctr u_rd_ctr (
    .axi_clk  (axi_clk),
    .rstn     (rstn),
    .inc      (rd_hs),
    .dec      (rd_done),
    .limit    (LIMIT),
    .count    (rd_outstanding),
    .at_limit (rd_full),
    .err      (rd_err)
  );

  assign err  = wr_err | rd_err;
  assign busy = avalid | (|wr_outstanding) | (|rd_outstanding);

`ifdef AXI_ARB_PERF_EN
  logic raw_stall;

  assign raw_stall = rd_req_valid & ~rd_full & ~raw_ok;

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      perf_wr_grants <= 32'd0;
      perf_rd_grants <= 32'd0;
      perf_raw_stall <= 32'd0;
    end else begin
      if (wr_hs)     perf_wr_grants <= perf_wr_grants + 32'd1;
      if (rd_hs)     perf_rd_grants <= perf_rd_grants + 32'd1;
      if (raw_stall) perf_raw_stall <= perf_raw_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed self-checking bench for axi_cmd_arbiter.
// Optional feature macro: AXI_ARB_PERF_EN (adds perf counter checks).
module tb_axi_cmd_arbiter;

  logic        axi_clk = 1'b0;
  logic        rstn;
  logic        wr_req_valid, rd_req_valid;
  logic [31:0] wr_req_addr, rd_req_addr;
  logic [7:0]  wr_req_len, rd_req_len;
  logic        aready, bvalid, bready;
  logic        rvalid, rready, rlast;

  logic        wr_req_ready, rd_req_ready;
  logic [7:0]  aid, alen;
  logic [31:0] aaddr;
  logic [2:0]  asize;
  logic [1:0]  aburst, alock;
  logic        avalid, atype, busy, err;
  logic [3:0]  wr_out, rd_out;

  logic        n_wr_ready, n_rd_ready;
  logic [7:0]  n_aid, n_alen;
  logic [31:0] n_aaddr;
  logic [2:0]  n_asize;
  logic [1:0]  n_aburst, n_alock;
  logic        n_avalid, n_atype, n_busy, n_err;
  logic [3:0]  n_wr_out, n_rd_out;

`ifdef AXI_ARB_PERF_EN
  logic [31:0] perf_wr, perf_rd, perf_raw;
  logic [31:0] n_perf_wr, n_perf_rd, n_perf_raw;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 axi_clk = ~axi_clk;

  axi_cmd_arbiter dut (
    .axi_clk        (axi_clk),
    .rstn           (rstn),
    .wr_req_valid   (wr_req_valid),
    .wr_req_addr    (wr_req_addr),
    .wr_req_len     (wr_req_len),
    .wr_req_ready   (wr_req_ready),
    .rd_req_valid   (rd_req_valid),
    .rd_req_addr    (rd_req_addr),
    .rd_req_len     (rd_req_len),
    .rd_req_ready   (rd_req_ready),
    .aid            (aid),
    .aaddr          (aaddr),
    .alen           (alen),
    .asize          (asize),
    .aburst         (aburst),
    .alock          (alock),
    .avalid         (avalid),
    .atype          (atype),
    .aready         (aready),
    .bvalid         (bvalid),
    .bready         (bready),
    .rvalid         (rvalid),
    .rready         (rready),
    .rlast          (rlast),
    .wr_outstanding (wr_out),
    .rd_outstanding (rd_out),
    .busy           (busy),
    .err            (err)
`ifdef AXI_ARB_PERF_EN
    ,
    .perf_wr_grants (perf_wr),
    .perf_rd_grants (perf_rd),
    .perf_raw_stall (perf_raw)
`endif
  );

  axi_cmd_arbiter #(.RAW_BLOCK(0)) dut_nr (
    .axi_clk        (axi_clk),
    .rstn           (rstn),
    .wr_req_valid   (wr_req_valid),
    .wr_req_addr    (wr_req_addr),
    .wr_req_len     (wr_req_len),
    .wr_req_ready   (n_wr_ready),
    .rd_req_valid   (rd_req_valid),
    .rd_req_addr    (rd_req_addr),
    .rd_req_len     (rd_req_len),
    .rd_req_ready   (n_rd_ready),
    .aid            (n_aid),
    .aaddr          (n_aaddr),
    .alen           (n_alen),
    .asize          (n_asize),
    .aburst         (n_aburst),
    .alock          (n_alock),
    .avalid         (n_avalid),
    .atype          (n_atype),
    .aready         (aready),
    .bvalid         (bvalid),
    .bready         (bready),
    .rvalid         (rvalid),
    .rready         (rready),
    .rlast          (rlast),
    .wr_outstanding (n_wr_out),
    .rd_outstanding (n_rd_out),
    .busy           (n_busy),
    .err            (n_err)
`ifdef AXI_ARB_PERF_EN
    ,
    .perf_wr_grants (n_perf_wr),
    .perf_rd_grants (n_perf_rd),
    .perf_raw_stall (n_perf_raw)
`endif
  );

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_req_valid = 0; wr_req_addr = 0; wr_req_len = 0;
    rd_req_valid = 0; rd_req_addr = 0; rd_req_len = 0;
    aready = 0; bvalid = 0; bready = 0;
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_inputs();
    repeat (2) @(posedge axi_clk);
    #1 rstn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({aaddr, alen, atype, avalid} !== 42'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h/%b/%b want 0",
               aaddr, alen, atype, avalid);
    end
    n_cmp++;
    if ({asize, aburst, alock, aid} !== {3'd5, 2'b01, 2'b00, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_const: got %0d/%b/%b/%h want 5/01/00/00",
               asize, aburst, alock, aid);
    end
    n_cmp++;
    if ({wr_out, rd_out, err, busy} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d/%0d/%b/%b want 0",
               wr_out, rd_out, err, busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    wr_req_valid = 1; wr_req_addr = 32'h100; wr_req_len = 8'd7;
    tick();
    n_cmp++;
    if ({avalid, atype, aaddr, alen, busy, wr_req_ready}
        !== {1'b1, 1'b1, 32'h100, 8'd7, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL single_addr: got v%b t%b a%h l%0d b%b r%b want v1 t1 a100 l7 b1 r0",
               avalid, atype, aaddr, alen, busy, wr_req_ready);
    end
    tick();
    aready = 1;
    #1;
    n_cmp++;
    if ({avalid, aaddr, wr_req_ready} !== {1'b1, 32'h100, 1'b1}) begin
      n_bad++;
      $display("FAIL single_ready: got v%b a%h r%b want v1 a100 r1",
               avalid, aaddr, wr_req_ready);
    end
    tick();
    wr_req_valid = 0; aready = 0;
    n_cmp++;
    if ({avalid, wr_out} !== {1'b0, 4'd1}) begin
      n_bad++;
      $display("FAIL single_count: got v%b c%0d want v0 c1", avalid, wr_out);
    end
    bvalid = 1; bready = 1;
    tick();
    bvalid = 0; bready = 0;
    n_cmp++;
    if ({wr_out, err} !== {4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_bresp: got c%0d e%b want c0 e0", wr_out, err);
    end
  endtask

  task automatic test_alternate();
    logic exp_t;
    do_reset();
    wr_req_valid = 1; wr_req_addr = 32'h200; wr_req_len = 8'd3;
    rd_req_valid = 1; rd_req_addr = 32'h300; rd_req_len = 8'd1;
    aready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        exp_t = (i % 4 == 0);
        n_cmp++;
        if ({n_avalid, n_atype, n_wr_ready, n_rd_ready}
            !== {1'b1, exp_t, exp_t, ~exp_t}) begin
          n_bad++;
          $display("FAIL alt_grant%0d: got v%b t%b wr%b rd%b want v1 t%b",
                   i / 2, n_avalid, n_atype, n_wr_ready, n_rd_ready, exp_t);
        end
      end
    end
    clear_inputs();
    n_cmp++;
    if ({n_wr_out, n_rd_out} !== {4'd2, 4'd2}) begin
      n_bad++;
      $display("FAIL alt_counts: got %0d/%0d want 2/2", n_wr_out, n_rd_out);
    end
  endtask

  task automatic test_raw_block();
    int rd_grants;
    logic granted;
    do_reset();
    wr_req_valid = 1; wr_req_addr = 32'h400; aready = 1;
    repeat (2) tick();
    wr_req_valid = 0;
    rd_req_valid = 1; rd_req_addr = 32'h400; rd_req_len = 8'd2;
    rd_grants = 0;
    repeat (20) begin
      tick();
      if (avalid) rd_grants++;
    end
    n_cmp++;
    if (rd_grants !== 0 || wr_out !== 4'd1) begin
      n_bad++;
      $display("FAIL raw_block: got grants %0d wr %0d want 0/1",
               rd_grants, wr_out);
    end
`ifdef AXI_ARB_PERF_EN
    n_cmp++;
    if (perf_raw !== 32'd20) begin
      n_bad++;
      $display("FAIL perf_raw: got %0d want 20", perf_raw);
    end
`endif
    bvalid = 1; bready = 1;
    tick();
    bvalid = 0; bready = 0;
    granted = 0;
    for (int k = 0; k < 2 && !granted; k++) begin
      tick();
      granted = avalid && (atype == 1'b0) && (aaddr == 32'h400);
    end
    n_cmp++;
    if (!granted) begin
      n_bad++;
      $display("FAIL raw_release: got v%b t%b a%h want read grant at 400",
               avalid, atype, aaddr);
    end
    tick();
    rd_req_valid = 0;
    n_cmp++;
    if ({rd_out, wr_out} !== {4'd1, 4'd0}) begin
      n_bad++;
      $display("FAIL raw_count: got rd%0d wr%0d want rd1 wr0", rd_out, wr_out);
    end
    clear_inputs();
  endtask

  task automatic test_limit();
    int grants;
    do_reset();
    wr_req_valid = 1; wr_req_addr = 32'h800; aready = 1;
    grants = 0;
    repeat (20) begin
      tick();
      if (wr_req_ready) grants++;
    end
    n_cmp++;
    if (grants !== 4 || wr_out !== 4'd4) begin
      n_bad++;
      $display("FAIL limit_cap: got grants %0d cnt %0d want 4/4", grants, wr_out);
    end
    bvalid = 1; bready = 1;
    tick();
    bvalid = 0; bready = 0;
    n_cmp++;
    if ({avalid, wr_out} !== {1'b0, 4'd3}) begin
      n_bad++;
      $display("FAIL limit_dec: got v%b c%0d want v0 c3", avalid, wr_out);
    end
    tick();
    n_cmp++;
    if ({avalid, atype, wr_req_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL limit_fifth: got v%b t%b r%b want 111",
               avalid, atype, wr_req_ready);
    end
    tick();
    wr_req_valid = 0;
    n_cmp++;
    if (wr_out !== 4'd4) begin
      n_bad++;
      $display("FAIL limit_refill: got %0d want 4", wr_out);
    end
`ifdef AXI_ARB_PERF_EN
    n_cmp++;
    if (perf_wr !== 32'd5) begin
      n_bad++;
      $display("FAIL perf_wr: got %0d want 5", perf_wr);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_inc_dec();
    do_reset();
    wr_req_valid = 1; wr_req_addr = 32'hA00; aready = 1;
    repeat (4) tick();
    n_cmp++;
    if (wr_out !== 4'd2) begin
      n_bad++;
      $display("FAIL incdec_pre: got %0d want 2", wr_out);
    end
    tick();
    bvalid = 1; bready = 1;
    tick();
    clear_inputs();
    n_cmp++;
    if ({wr_out, err} !== {4'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL incdec: got c%0d e%b want c2 e0", wr_out, err);
    end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    rvalid = 1; rready = 1; rlast = 1;
    tick();
    clear_inputs();
    n_cmp++;
    if ({err, rd_out} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL underflow: got e%b c%0d want e1 c0", err, rd_out);
    end
    wr_req_valid = 1; wr_req_addr = 32'hC00;
    tick();
    n_cmp++;
    if (avalid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre: got avalid %b want 1", avalid);
    end
    #2 rstn = 0;
    #1;
    n_cmp++;
    if ({avalid, err, wr_out, rd_out} !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset: got v%b e%b w%0d r%0d want 0",
               avalid, err, wr_out, rd_out);
    end
    do_reset();
  endtask

  initial begin
    rstn = 0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_raw_block();
    test_limit();
    test_inc_dec();
    test_underflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axi_cmd_arbiter.md
Name: axi_cmd_arbiter

Overview:
- Shares the single combined AXI address channel (aaddr/avalid/atype, one channel for both directions) of the DDR port between two requesters.
  - The write requester is the UART/async-FIFO write path.
  - The read requester is the readback/compare path.
- Tracks outstanding write and read bursts, and blocks reads while writes are in flight (read-after-write ordering).
- Sits between the requesters and the DDR controller's AXI slave.

Parameters:
- ASIZE, 5: beat size code driven on asize (32 bytes/beat).
- MAX_OUT, 4: maximum outstanding bursts per direction, range 1..15.
- RAW_BLOCK, 1: 1 means a read is not granted while wr_outstanding != 0.
- AXI_ID, 8'h00: constant value driven on aid.

Ports:
- axi_clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- wr_req_valid  in  1  write burst request; held until wr_req_ready
- wr_req_addr  in  32  write burst start address
- wr_req_len  in  8  write burst length minus 1
- wr_req_ready  out  1  one-cycle pulse: write address accepted by slave
- rd_req_valid  in  1  read burst request; held until rd_req_ready
- rd_req_addr  in  32  read burst start address
- rd_req_len  in  8  read burst length minus 1
- rd_req_ready  out  1  one-cycle pulse: read address accepted by slave
- aid  out  8  AXI_ID
- aaddr  out  32  address
- alen  out  8  burst length
- asize  out  3  ASIZE
- aburst  out  2  2'b01 (INCR)
- alock  out  2  2'b00
- avalid  out  1  address valid
- atype  out  1  1 = write, 0 = read
- aready  in  1  slave accepts address
- bvalid  in  1  write response valid (monitored)
- bready  in  1  write response ready from data master (monitored)
- rvalid  in  1  read data valid (monitored)
- rready  in  1  read ready (monitored)
- rlast  in  1  last read beat (monitored)
- wr_outstanding  out  4  in-flight write bursts
- rd_outstanding  out  4  in-flight read bursts
- busy  out  1  avalid, or either outstanding count != 0
- err  out  1  sticky: response seen with count at 0

Behaviour:
- Reset values:
  - Data outputs: aaddr=0, alen=0, atype=0.
  - Constant outputs: asize=ASIZE, aburst=2'b01, alock=0, aid=AXI_ID.
  - avalid=0, both counts=0, err=0, last_grant=read.
  - FSM enters IDLE.
- Reset asserted mid-operation clears everything immediately, including a pending avalid. Requesters must re-issue.
- Eligibility:
  - Write is eligible when wr_req_valid and wr_outstanding < MAX_OUT.
  - Read is eligible when rd_req_valid, rd_outstanding < MAX_OUT, and (RAW_BLOCK=0 or wr_outstanding == 0).
- FSM has two states, IDLE and ADDR.
  - IDLE: if any request is eligible, register the winner's addr/len/type into aaddr/alen/atype, set avalid=1, and go to ADDR.
    - Latency: request to avalid is one cycle.
  - Arbitration when both are eligible: round-robin. The direction opposite last_grant wins.
  - ADDR: avalid held and aaddr/alen/atype held stable until aready.
    - On avalid&aready: pulse wr_req_ready or rd_req_ready combinationally in that same cycle.
    - Then increment the matching count, update last_grant, set avalid=0 next cycle, and return to IDLE.
    - Minimum spacing between grants is 2 cycles.
  - No re-arbitration is allowed while in ADDR.
- Counters:
  - wr_outstanding: +1 on write handshake, -1 on bvalid&bready.
  - rd_outstanding: +1 on read handshake, -1 on rvalid&rready&rlast.
  - A simultaneous +1 and -1 leaves the count unchanged.
  - A decrement at 0 saturates at 0 and sets err, which stays set until reset.
- Address is passed through unmodified; the requester guarantees 32-byte alignment and no 4 KB crossing.
- A request dropped before ready is a protocol violation. Behaviour is undefined, except that aaddr stays stable while avalid is high.

Optional Feature:
- Macro: AXI_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_wr_grants[31:0], perf_rd_grants[31:0], perf_raw_stall[31:0].
  - The grant counters count handshakes.
  - perf_raw_stall counts cycles with rd_req_valid high and the read blocked only by RAW_BLOCK.
  - All three wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package axi_arb_pkg holds:
  - state encoding (IDLE=1'b0, ADDR=1'b1);
  - BURST_INCR=2'b01;
  - LOCK_NORMAL=2'b00;
  - TYPE_WR=1'b1, TYPE_RD=1'b0.
- Sub-module axi_outstanding_ctr (inc, dec, limit, count, at_limit, underflow err) is instantiated twice.

Test Plan:
- Single write: wr_req addr 0x100, len 7, aready high on the 2nd avalid cycle -> avalid=1, atype=1, aaddr=0x100, alen=7, one wr_req_ready pulse, wr_outstanding=1; after bvalid&bready it returns to 0.
- Simultaneous write and read requests, RAW_BLOCK=0, aready always 1, MAX_OUT=4:
  - Grants alternate W, R, W, R, starting with W after reset, since last_grant resets to read.
  - Counts reach 2/2.
- RAW block: write granted, no bvalid, rd_req held 20 cycles -> no read grant. bvalid&bready asserted -> read granted within 2 cycles.
- Outstanding limit: 5 write requests, MAX_OUT=4, no bvalid -> exactly 4 grants; the 5th is granted one cycle after the first bvalid&bready.
- Simultaneous increment and decrement: write handshake in the same cycle as bvalid&bready with count 2 -> count stays 2, err=0.
- Underflow and reset:
  - rvalid&rready&rlast with rd_outstanding=0 -> err=1, count stays 0.
  - rstn asserted while avalid=1 -> avalid=0, err=0, counts 0 immediately.
